// File: rtl/alu_mc_if.sv
// Opcode package and request/response interface for alu_mc.
// The package carries the ALUCtrl_i encodings shared by the design and its users.

package alu_mc_pkg;

    // ALUCtrl_i opcode encodings
    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_XOR  = 3'd1,
        OP_SLL  = 3'd2,
        OP_ADD  = 3'd3,
        OP_SUB  = 3'd4,
        OP_MUL  = 3'd5,
        OP_ADDI = 3'd6,
        OP_SRAI = 3'd7
    } alu_op_e;

endpackage

// Request (valid_i/ready_o) and result (valid_o/ready_i) handshakes plus data.
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic [2:0]       ALUCtrl_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] data_o;
    logic             zero_o;

    // Requester / result consumer side
    modport master (
        output valid_i, data1_i, data2_i, ALUCtrl_i, ready_i,
        input  ready_o, valid_o, data_o, zero_o
    );

    // ALU side
    modport slave (
        input  valid_i, data1_i, data2_i, ALUCtrl_i, ready_i,
        output ready_o, valid_o, data_o, zero_o
    );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: handshaked ALU with registered result (IDLE/BUSY/DONE control).
// Ops: AND, XOR, SLL, ADD, SUB, MUL, ADDI, SRAI on WIDTH-bit two's-complement data.
// Build option: define ALU_MC_MUL_ITER_EN to compute MUL with a shift-add
// iterator (WIDTH cycles in BUSY); otherwise MUL completes in one cycle.

module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic     clk_i,
    input  logic     rst_i,
    alu_mc_if.slave  bus
);
    import alu_mc_pkg::*;

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state;
    logic             accept;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] comb_res;
    alu_op_e          op;

`ifdef ALU_MC_MUL_ITER_EN
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [SHW-1:0]   cnt;
`endif

    // Accept in IDLE, or in DONE when the current result is consumed this cycle
    assign bus.ready_o = (state == IDLE) || ((state == DONE) && bus.ready_i);
    assign accept      = bus.valid_i && bus.ready_o;
    assign shamt       = bus.data2_i[SHW-1:0];
    assign op          = alu_op_e'(bus.ALUCtrl_i);

    // Single-cycle datapath for every op handled without the iterator
    always_comb begin
        comb_res = '0;
        case (op)
            OP_AND:  comb_res = bus.data1_i & bus.data2_i;
            OP_XOR:  comb_res = bus.data1_i ^ bus.data2_i;
            OP_SLL:  comb_res = bus.data1_i << shamt;
            OP_ADD:  comb_res = bus.data1_i + bus.data2_i;
            OP_SUB:  comb_res = bus.data1_i - bus.data2_i;
`ifdef ALU_MC_MUL_ITER_EN
            OP_MUL:  comb_res = '0;
`else
            OP_MUL:  comb_res = bus.data1_i * bus.data2_i;
`endif
            OP_ADDI: comb_res = bus.data1_i + bus.data2_i;
            OP_SRAI: comb_res = $unsigned($signed(bus.data1_i) >>> shamt);
            default: comb_res = '0;
        endcase
    end

`ifdef ALU_MC_MUL_ITER_EN
    // Partial-product accumulation for the current iteration
    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end
`endif

    // Control FSM with registered result, valid and zero flag
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            bus.valid_o <= 1'b0;
            bus.data_o  <= '0;
            bus.zero_o  <= 1'b0;
`ifdef ALU_MC_MUL_ITER_EN
            cnt         <= '0;
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
`ifdef ALU_MC_MUL_ITER_EN
                        if (op == OP_MUL) begin
                            state       <= BUSY;
                            bus.valid_o <= 1'b0;
                            bus.zero_o  <= 1'b0;
                            acc         <= '0;
                            mcand       <= bus.data1_i;
                            mplier      <= bus.data2_i;
                            cnt         <= '0;
                        end else
`endif
                        begin
                            state       <= DONE;
                            bus.valid_o <= 1'b1;
                            bus.data_o  <= comb_res;
                            bus.zero_o  <= (comb_res == '0);
                        end
                    end else if ((state == DONE) && bus.ready_i) begin
                        // Result consumed with no follow-on request; data_o keeps its last value
                        state       <= IDLE;
                        bus.valid_o <= 1'b0;
                        bus.zero_o  <= 1'b0;
                    end
                end
                BUSY: begin
`ifdef ALU_MC_MUL_ITER_EN
                    if (cnt == SHW'(WIDTH - 1)) begin
                        state       <= DONE;
                        bus.valid_o <= 1'b1;
                        bus.data_o  <= acc_next;
                        bus.zero_o  <= (acc_next == '0);
                        cnt         <= '0;
                    end else begin
                        acc    <= acc_next;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + SHW'(1);
                    end
`else
                    state <= IDLE;
`endif
                end
                default: begin
                    state       <= IDLE;
                    bus.valid_o <= 1'b0;
                    bus.zero_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal 8..64, power of two).
REQ-002 SHALL have localparam SHW = log2(WIDTH), the shift-amount width.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset; synchronous, active-low.
REQ-005 valid_i  input  1  request valid.
REQ-006 ready_o  output  1  block can accept a request this cycle.
REQ-007 data1_i  input  WIDTH  signed operand 1.
REQ-008 data2_i  input  WIDTH  signed operand 2 or shift amount.
REQ-009 ALUCtrl_i  input  3  op code, define.v encodings: AND, XOR, SLL, ADD, SUB, MUL, ADDI, SRAI.
REQ-010 valid_o  output  1  result valid.
REQ-011 ready_i  input  1  consumer accepts result this cycle.
REQ-012 data_o  output  WIDTH  signed registered result.
REQ-013 zero_o  output  1  registered; high when data_o == 0, qualified by valid_o.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-015 ready_o SHALL be high in IDLE, and in DONE when ready_i is high; low in BUSY.
REQ-016 Accept SHALL occur on a cycle with valid_i & ready_o; operands and op code SHALL be captured at accept; inputs at any other time SHALL be ignored.
REQ-017 Non-MUL ops SHALL go to DONE with registered result; valid_o high the cycle after accept (latency 1).
REQ-018 AND/XOR/ADD/SUB/ADDI SHALL be bitwise/two's-complement WIDTH-bit, overflow wrapping silently.
REQ-019 SLL SHALL shift data1 left by data2[SHW-1:0]; SRAI SHALL shift arithmetic right by data2[SHW-1:0]; upper data2 bits ignored.
REQ-020 MUL SHALL yield the low WIDTH bits of data1*data2.
REQ-021 In DONE, valid_o SHALL stay high and data_o/zero_o SHALL stay stable until ready_i is high.
REQ-022 DONE & ready_i & valid_i SHALL accept the new request in the same cycle (back-to-back, one result per cycle for non-MUL ops); DONE & ready_i & !valid_i SHALL go to IDLE.
REQ-023 valid_o SHALL be low in IDLE and BUSY.

Reset
REQ-024 While rst_i is low at a clock edge: state IDLE, valid_o 0, data_o 0, zero_o 0, iteration counter 0.
REQ-025 Reset asserted mid-operation (BUSY or DONE) SHALL abort it with no result delivered; ready_o high the first cycle after reset release.

Configuration
REQ-026 Macro ALU_MC_MUL_ITER_EN defined: MUL SHALL use a shift-add iterator, one partial product per cycle, WIDTH cycles in BUSY, valid_o high WIDTH+1 cycles after accept.
REQ-027 Macro undefined: MUL SHALL be combinational like other ops, latency 1, BUSY never entered.

Verification (WIDTH=32)
REQ-028 ADD 5, -3 -> data_o 0x00000002, zero_o 0, valid_o one cycle after accept.
REQ-029 SUB 7, 7 -> data_o 0, zero_o 1; SRAI 0x80000000, 4 -> 0xF8000000; SLL 1, 33 -> 0x00000002.
REQ-030 MUL -6, 7 with ALU_MC_MUL_ITER_EN -> 0xFFFFFFD6 exactly 33 cycles after accept, ready_o low for 32 cycles; without macro -> same value after 1 cycle.
REQ-031 Result held with ready_i low 3 cycles -> data_o, valid_o unchanged; ready_i high with valid_i (XOR 0xF0, 0xFF) -> new request accepted same cycle, 0x0F next cycle.
REQ-032 rst_i low during BUSY cycle 10 of a MUL -> next cycle valid_o 0, data_o 0; after release ready_o 1 and next ADD correct.
REQ-033 valid_i pulsed with different operands during BUSY -> ignored; MUL result unaffected.
